// File: rtl/hud_update_scheduler.sv
// Purpose: owns the HUD field registers and applies buffered SET/INC/DEC ops with saturation and flash strobes.
// Latency: a request is applied two edges after it is posted when uncontended, at most N_CH+1 edges under full load.
// Backpressure: one op buffered per channel (busy); a request on a busy channel is dropped and flagged in overflow.
module hud_update_scheduler #(
    parameter int              N_CH         = 7,
    parameter logic [7:0]      MAX_VAL      = 8'd99,
    parameter logic [8*N_CH-1:0] INIT_VALS  = {8'd1, 8'd0, 8'd1, 8'd3, 8'd1, 8'd3, 8'd99},
    parameter logic [7:0]      FLASH_FRAMES = 8'd30
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                startOfFrame,
    input  logic [N_CH-1:0]     req,
    input  logic [2*N_CH-1:0]   op,
    input  logic [8*N_CH-1:0]   data,
    output logic [N_CH-1:0]     busy,
    output logic [N_CH-1:0]     ack,
    output logic [N_CH-1:0]     overflow,
    input  logic                clrOverflow,
    output logic [8*N_CH-1:0]   values,
    output logic [N_CH-1:0]     flash
);

    localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam logic [1:0] OP_SET = 2'd0;
    localparam logic [1:0] OP_INC = 2'd1;
    localparam logic [1:0] OP_DEC = 2'd2;

    logic [7:0]      val_q   [N_CH];
    logic [1:0]      op_q    [N_CH];
    logic [7:0]      dat_q   [N_CH];
    logic [7:0]      cnt_q   [N_CH];
    logic [7:0]      cnt_nxt [N_CH];
    logic [N_CH-1:0] pend_q;
    logic [PW-1:0]   ptr_q;

    logic            gnt_vld;
    logic [PW-1:0]   gnt_idx;
    logic [N_CH-1:0] gnt_oh;
    logic [PW:0]     scan;
    logic [N_CH-1:0] drop;
    logic [N_CH-1:0] take;
    logic [7:0]      old_val;
    logic [7:0]      new_val;
    logic [8:0]      sum9;

    // A request on an already-pending channel is lost, regardless of whether that channel is granted now.
    assign drop = req & pend_q;
    assign take = req & ~pend_q;
    assign busy = pend_q;

    // Round-robin scan starting at the pointer; first pending channel wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        scan    = '0;
        for (int k = 0; k < N_CH; k++) begin
            scan = {1'b0, ptr_q} + (PW+1)'(k);
            if (scan >= (PW+1)'(N_CH)) begin
                scan = scan - (PW+1)'(N_CH);
            end
            if (!gnt_vld && pend_q[scan[PW-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = scan[PW-1:0];
            end
        end
        gnt_oh = gnt_vld ? (N_CH'(1) << gnt_idx) : '0;
    end

    // Saturating arithmetic for the granted channel, using a 9-bit sum so INC cannot wrap.
    always_comb begin
        old_val = val_q[gnt_idx];
        new_val = old_val;
        sum9    = '0;
        case (op_q[gnt_idx])
            OP_SET: new_val = (dat_q[gnt_idx] > MAX_VAL) ? MAX_VAL : dat_q[gnt_idx];
            OP_INC: begin
                sum9    = {1'b0, old_val} + {1'b0, dat_q[gnt_idx]};
                new_val = (sum9 > {1'b0, MAX_VAL}) ? MAX_VAL : sum9[7:0];
            end
            OP_DEC: new_val = (dat_q[gnt_idx] > old_val) ? 8'd0 : old_val - dat_q[gnt_idx];
            default: new_val = old_val;
        endcase
    end

    // Flash counter next state: a change reloads, otherwise each frame counts down to zero.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            cnt_nxt[i] = cnt_q[i];
            if (gnt_oh[i] && (new_val != old_val)) begin
                cnt_nxt[i] = FLASH_FRAMES;
            end else if (startOfFrame && (cnt_q[i] != 8'd0)) begin
                cnt_nxt[i] = cnt_q[i] - 8'd1;
            end
        end
    end

    // Per-channel operation buffer and pending flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (take[i]) begin
                    op_q[i]  <= op[2*i +: 2];
                    dat_q[i] <= data[8*i +: 8];
                end
            end
            pend_q <= (pend_q & ~gnt_oh) | take;
        end
    end

    // Apply the granted operation, pulse its ack and advance the round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                val_q[i] <= INIT_VALS[8*i +: 8];
            end
            ack   <= '0;
            ptr_q <= '0;
        end else begin
            ack <= gnt_oh;
            if (gnt_vld) begin
                val_q[gnt_idx] <= new_val;
                ptr_q <= (gnt_idx == PW'(N_CH-1)) ? '0 : gnt_idx + PW'(1);
            end
        end
    end

    // Flash counters and their registered nonzero strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= 8'd0;
            end
            flash <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= cnt_nxt[i];
                flash[i] <= (cnt_nxt[i] != 8'd0);
            end
        end
    end

    // Sticky drop flags; a new drop beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= '0;
        end else begin
            overflow <= (clrOverflow ? '0 : overflow) | drop;
        end
    end

    // Flatten the value registers onto the drawer bus.
    always_comb begin
        values = '0;
        for (int i = 0; i < N_CH; i++) begin
            values[8*i +: 8] = val_q[i];
        end
    end

endmodule

// File: tb/tb_hud_update_scheduler.sv
// Purpose: checks hud_update_scheduler against a behavioural model plus literal expectations.
// Latency: outputs compared every falling edge after the rising edge that produced them.
// Backpressure: stimulus deliberately re-requests busy channels to exercise drops.
module tb_hud_update_scheduler;

    localparam int          N    = 7;
    localparam logic [55:0] INIT = {8'd1, 8'd0, 8'd1, 8'd3, 8'd1, 8'd3, 8'd99};

    logic        clk = 1'b0;
    logic        reset;
    logic        startOfFrame;
    logic        clrOverflow;
    logic [6:0]  req;
    logic [13:0] op;
    logic [55:0] data;
    logic [6:0]  busy;
    logic [6:0]  ack;
    logic [6:0]  overflow;
    logic [6:0]  flash;
    logic [55:0] values;

    hud_update_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .startOfFrame (startOfFrame),
        .req          (req),
        .op           (op),
        .data         (data),
        .busy         (busy),
        .ack          (ack),
        .overflow     (overflow),
        .clrOverflow  (clrOverflow),
        .values       (values),
        .flash        (flash)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int       m_val [N];
    bit       m_pend[N];
    int       m_op  [N];
    int       m_dat [N];
    int       m_cnt [N];
    int       m_ptr;
    bit [6:0] m_ack;
    bit [6:0] m_ovf;
    bit       chk_en = 1'b0;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    always @(posedge clk) begin : model
        int g;
        int nv;
        bit was_pend[N];
        bit load[N];
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                m_val[i]  = int'(INIT[8*i +: 8]);
                m_pend[i] = 1'b0;
                m_cnt[i]  = 0;
            end
            m_ptr = 0;
            m_ack = '0;
            m_ovf = '0;
        end else begin
            g = -1;
            for (int k = 0; k < N; k++) begin
                if (g < 0 && m_pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
            for (int i = 0; i < N; i++) begin
                was_pend[i] = m_pend[i];
                load[i]     = 1'b0;
            end
            m_ack = '0;
            if (g >= 0) begin
                case (m_op[g])
                    0:       nv = imin(m_dat[g], 99);
                    1:       nv = imin(m_val[g] + m_dat[g], 99);
                    2:       nv = (m_dat[g] > m_val[g]) ? 0 : m_val[g] - m_dat[g];
                    default: nv = m_val[g];
                endcase
                load[g]   = (nv != m_val[g]);
                m_val[g]  = nv;
                m_ack[g]  = 1'b1;
                m_pend[g] = 1'b0;
                m_ptr     = (g + 1) % N;
            end
            if (clrOverflow) m_ovf = '0;
            for (int i = 0; i < N; i++) begin
                if (req[i]) begin
                    if (was_pend[i]) begin
                        m_ovf[i] = 1'b1;
                    end else begin
                        m_pend[i] = 1'b1;
                        m_op[i]   = int'(op[2*i +: 2]);
                        m_dat[i]  = int'(data[8*i +: 8]);
                    end
                end
            end
            for (int i = 0; i < N; i++) begin
                if (load[i]) m_cnt[i] = 30;
                else if (startOfFrame && m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
            end
        end
    end

    // Compare every cycle once the model has seen a reset.
    always @(negedge clk) begin : compare
        logic [55:0] ev;
        logic [6:0]  eb;
        logic [6:0]  ef;
        if (chk_en) begin
            for (int i = 0; i < N; i++) begin
                ev[8*i +: 8] = 8'(m_val[i]);
                eb[i]        = m_pend[i];
                ef[i]        = (m_cnt[i] != 0);
            end
            check("model_values",   64'(values),   64'(ev));
            check("model_busy",     64'(busy),     64'(eb));
            check("model_ack",      64'(ack),      64'(m_ack));
            check("model_overflow", 64'(overflow), 64'(m_ovf));
            check("model_flash",    64'(flash),    64'(ef));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle();
        req          = '0;
        startOfFrame = 1'b0;
        clrOverflow  = 1'b0;
        reset        = 1'b0;
    endtask

    task automatic post(input int ch, input logic [1:0] o, input logic [7:0] d);
        req[ch]         = 1'b1;
        op[2*ch +: 2]   = o;
        data[8*ch +: 8] = d;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin : main
        idle();
        op   = '0;
        data = '0;
        do_reset();
        chk_en = 1'b1;

        // Reset state.
        check("rst_values",   64'(values),        64'(INIT));
        check("rst_timer",    64'(values[7:0]),   64'd99);
        check("rst_score",    64'(values[47:40]), 64'd0);
        check("rst_busy",     64'(busy),          64'd0);
        check("rst_ack",      64'(ack),           64'd0);
        check("rst_flash",    64'(flash),         64'd0);
        check("rst_overflow", 64'(overflow),      64'd0);

        // SET score to 42, then watch it flash for exactly 30 frames.
        post(5, 2'd0, 8'd42);
        cyc();
        idle();
        check("set_busy_t1", 64'(busy[5]), 64'd1);
        cyc();
        check("set_val_t2",  64'(values[47:40]), 64'd42);
        check("set_ack_t2",  64'(ack),           64'h20);
        check("set_flash",   64'(flash[5]),      64'd1);
        for (int f = 0; f < 30; f++) begin
            startOfFrame = 1'b1;
            cyc();
            startOfFrame = 1'b0;
            if (f == 28) check("flash_29", 64'(flash[5]), 64'd1);
        end
        check("flash_30", 64'(flash[5]), 64'd0);

        // Lives: DEC clamps at 0, SET clamps at 99, INC saturated produces no change.
        post(1, 2'd2, 8'd5);
        cyc(); idle(); cyc();
        check("dec_floor", 64'(values[15:8]), 64'd0);
        post(1, 2'd0, 8'd200);
        cyc(); idle(); cyc();
        check("set_clamp", 64'(values[15:8]), 64'd99);
        post(1, 2'd1, 8'd1);
        cyc(); idle(); cyc();
        check("inc_sat",     64'(values[15:8]), 64'd99);
        check("inc_sat_ack", 64'(ack),          64'h02);

        // Two full bursts from pointer 0 must ack in channel order.
        do_reset();
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < N; i++) post(i, 2'd1, 8'd1);
            cyc();
            idle();
            for (int i = 0; i < N; i++) begin
                cyc();
                check("burst_ack", 64'(ack), 64'(7'd1 << i));
            end
        end

        // Back-to-back requests on channel 2: second is dropped.
        post(2, 2'd0, 8'd5);
        cyc();
        post(2, 2'd0, 8'd7);
        cyc();
        idle();
        check("drop_ack",  64'(ack[2]),      64'd1);
        check("drop_ovf",  64'(overflow[2]), 64'd1);
        cyc();
        check("drop_once", 64'(ack[2]),        64'd0);
        check("drop_val",  64'(values[23:16]), 64'd5);
        clrOverflow = 1'b1;
        cyc();
        idle();
        check("ovf_clr", 64'(overflow[2]), 64'd0);
        post(2, 2'd2, 8'd1);
        cyc();
        post(2, 2'd2, 8'd1);
        clrOverflow = 1'b1;
        cyc();
        idle();
        check("ovf_set_wins", 64'(overflow[2]), 64'd1);
        cyc();

        // Reset with channels 3 and 4 pending discards both.
        post(3, 2'd0, 8'd50);
        post(4, 2'd0, 8'd60);
        cyc();
        idle();
        check("pend_34", 64'(busy), 64'h18);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("mid_rst_busy", 64'(busy),   64'd0);
        check("mid_rst_ack",  64'(ack),    64'd0);
        check("mid_rst_vals", 64'(values), 64'(INIT));
        cyc();
        check("mid_rst_noack", 64'(ack), 64'd0);

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            reset        = ($urandom_range(0, 699) == 0);
            startOfFrame = ($urandom_range(0, 3) == 0);
            clrOverflow  = ($urandom_range(0, 15) == 0);
            for (int i = 0; i < N; i++) begin
                req[i]          = ($urandom_range(0, 3) == 0);
                op[2*i +: 2]    = 2'($urandom_range(0, 3));
                data[8*i +: 8]  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 9))
                                                              : 8'($urandom_range(0, 255));
            end
            cyc();
        end
        idle();
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
